// File: rtl/scale_mux_arbiter_pkg.sv
// Shared types and sizing helpers for the two-requester burst arbiter.
package scale_mux_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} arb_state_t;
    typedef enum logic {REQ_B = 1'b0, REQ_A = 1'b1} req_id_t;

    localparam int MAX_BURST_DFLT = 4;

    // Counter must hold 0..MAX_BURST-1; one extra code keeps MAX_BURST=1 at a legal width.
    function automatic int burst_cnt_w(input int max_burst = MAX_BURST_DFLT);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/scale_mux_arbiter_if.sv
// Handshake bundle between two producers, the arbiter, and the single consumer.
interface scale_mux_arbiter_if #(parameter int WIDTH = 8);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_last;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_last;
    logic             b_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;
    logic             sel;
    logic             busy;

    modport slave (
        input  a_valid, a_data, a_last,
        output a_ready,
        input  b_valid, b_data, b_last,
        output b_ready,
        output out_valid, out_data, out_last,
        input  out_ready,
        output sel, busy
    );

    modport master (
        output a_valid, a_data, a_last,
        input  a_ready,
        output b_valid, b_data, b_last,
        input  b_ready,
        input  out_valid, out_data, out_last,
        output out_ready,
        input  sel, busy
    );
endinterface

// File: rtl/scale_mux_arbiter_mux.sv
// Plain WIDTH-bit 2:1 select: sel=1 passes a, sel=0 passes b.
module scale_mux #(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = sel ? a : b;
endmodule

// File: rtl/scale_mux_arbiter.sv
// Round-robin burst arbiter for two valid/ready producers feeding one
// registered output stage through a shared 2:1 select.
module scale_mux_arbiter
    import scale_mux_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    scale_mux_arbiter_if.slave   bus
);

    localparam int                CNT_W    = burst_cnt_w(MAX_BURST);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t       state_q, state_d;
    req_id_t          last_served_q, last_served_d;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;

    logic [WIDTH-1:0] mux_data;
    logic             can_load;
    logic             a_ready;
    logic             b_ready;
    logic             accept;
    logic             granted_last;
    logic             burst_end;

    scale_mux #(.WIDTH(WIDTH)) u_mux (
        .sel (sel_q),
        .a   (bus.a_data),
        .b   (bus.b_data),
        .y   (mux_data)
    );

    // The output register can take a beat when empty or draining this cycle.
    always_comb begin
        can_load     = !out_valid_q || bus.out_ready;
        a_ready      = (state_q == GRANT_A) && can_load;
        b_ready      = (state_q == GRANT_B) && can_load;
        accept       = (a_ready && bus.a_valid) || (b_ready && bus.b_valid);
        granted_last = (state_q == GRANT_A) ? bus.a_last : bus.b_last;
        burst_end    = granted_last || (burst_cnt_q == CNT_LAST);
    end

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        sel_d         = sel_q;
        burst_cnt_d   = burst_cnt_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;

        case (state_q)
            IDLE: begin
                // On a tie the requester not served last wins.
                if (bus.a_valid && (!bus.b_valid || last_served_q == REQ_B)) begin
                    state_d = GRANT_A;
                    sel_d   = 1'b1;
                end else if (bus.b_valid) begin
                    state_d = GRANT_B;
                    sel_d   = 1'b0;
                end
            end
            GRANT_A, GRANT_B: begin
                if (accept) begin
                    if (burst_end) begin
                        state_d       = IDLE;
                        last_served_d = (state_q == GRANT_A) ? REQ_A : REQ_B;
                        burst_cnt_d   = '0;
                    end else begin
                        burst_cnt_d   = burst_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            out_last_d  = burst_end;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_served_q <= REQ_B;
            sel_q         <= 1'b0;
            burst_cnt_q   <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            sel_q         <= sel_d;
            burst_cnt_q   <= burst_cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
        end
    end

    assign bus.a_ready   = a_ready;
    assign bus.b_ready   = b_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/scale_mux_arbiter.md
Name: scale_mux_arbiter

Overview:
- Two-requester round-robin arbiter that shares one WIDTH-bit 2:1 select datapath, where sel=1 passes input A and sel=0 passes input B.
- Each requester presents data with a valid/ready handshake. The arbiter grants one requester per burst, drives the mux select, and captures the selected beat into a one-entry registered output stage.
- It sits between two producer blocks and a single downstream consumer.

Parameters:
- WIDTH, 8, data width of each requester and of the output.
- MAX_BURST, 4, maximum beats per grant before forced re-arbitration. Legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  requester A has a beat.
- a_data  input  WIDTH  requester A data.
- a_last  input  1  beat is the last of A's packet.
- a_ready  output  1  A beat accepted this cycle (a_valid && a_ready).
- b_valid  input  1  requester B has a beat.
- b_data  input  WIDTH  requester B data.
- b_last  input  1  beat is the last of B's packet.
- b_ready  output  1  B beat accepted this cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered output data.
- out_last  output  1  registered burst-end marker.
- out_ready  input  1  consumer accepts the beat.
- sel  output  1  mux select: 1 = A, 0 = B. Registered.
- busy  output  1  a grant is active (state != IDLE).

Behaviour:
- Reset, synchronous: state=IDLE, sel=0, busy=0, a_ready=b_ready=0, out_valid=0, out_data=0, out_last=0, burst_cnt=0, last_served=B. A therefore wins the first tie.
- States: IDLE, GRANT_A, GRANT_B.
- IDLE transitions:
  - Only a_valid → GRANT_A. Only b_valid → GRANT_B.
  - Both valid → grant the requester that is not last_served.
  - Neither valid → stay in IDLE.
  - sel updates on the same edge as the grant. No input beat is accepted in IDLE.
- Acceptance while granted:
  - can_load = !out_valid || out_ready.
  - a_ready = (state==GRANT_A) && can_load. b_ready = (state==GRANT_B) && can_load. Both readies are combinational from state and out_valid/out_ready.
  - Never both high. Never high in IDLE.
- On an accepted beat:
  - out_data ← muxed data (sel=1 → a_data, else b_data). out_valid ← 1. burst_cnt increments.
  - end = granted input's last, OR burst_cnt == MAX_BURST-1.
  - out_last ← end.
  - On end: state → IDLE, last_served ← granted requester, burst_cnt ← 0.
- Output stage: if out_valid && out_ready && no new load, out_valid ← 0. Simultaneous drain and load gives full throughput: one beat per cycle during a burst.
- Latency and throughput:
  - Request asserted in IDLE at cycle N → grant at edge N+1 → first beat accepted during cycle N+1 → out_valid at N+2.
  - Re-arbitration costs one IDLE bubble per burst.
- Stalls: out_ready low with out_valid high → the granted ready goes low. The input holds its data; a_valid/a_data must stay stable until accepted (producer rule). out_data is stable while out_valid && !out_ready.
- Valid dropped mid-grant (a packet gap): the state stays granted and waits. No timeout.
- MAX_BURST=1: every beat ends a burst, so A and B alternate strictly when both are valid.
- The non-granted requester's valid is ignored until the next IDLE.
- Reset mid-burst: any partially transferred packet is discarded and the pending output beat is dropped. The next grant after reset goes to A on a tie.

Decomposition:
- Package scale_mux_arb_pkg:
  - typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} arb_state_t
  - typedef enum logic {REQ_B=1'b0, REQ_A=1'b1} req_id_t
  - function burst_cnt_w() returning $clog2(MAX_BURST+1)
- Sub-module: instantiate the existing scale_mux #(WIDTH) for the data select. All control lives in scale_mux_arbiter.

Test Plan:
- Reset, then a_valid=1 with 3 beats 0x11, 0x12, 0x13 (last on 0x13), out_ready=1, b idle:
  - sel=1 one cycle after the request.
  - out_data 0x11, 0x12, 0x13 on consecutive cycles; out_last only on 0x13.
  - busy then drops.
- Both requesters continuously valid, packets of 2 beats, MAX_BURST=4: grant order A, B, A, B, with one idle cycle between bursts. Never two consecutive A bursts.
- A packet of 6 beats (last on beat 6) with MAX_BURST=4 and B valid:
  - A sends 4 beats; out_last is forced on beat 4.
  - B is served next, then A resumes with beats 5-6.
- Backpressure: out_ready=0 for 3 cycles mid-burst:
  - a_ready=0 and out_data is held for those cycles.
  - No beat is lost or duplicated; the sequence resumes on the cycle out_ready=1.
- rst asserted for 1 cycle in the middle of B's burst:
  - The next cycle shows all outputs at their reset values.
  - With both requesters valid afterwards, A is granted first.
